// File: rtl/mod_counter_cascade.sv
// Multi-digit modulo-MODULUS up/down counter with synchronous clear/load,
// saturate option and cascade in/out for chaining instances into wider counters.
module mod_counter_cascade #(
  parameter int DIGITS   = 2,
  parameter int DW       = 4,
  parameter int MODULUS  = 10,
  parameter int SATURATE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 cin,
  input  logic                 up,
  input  logic                 clr,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_val,
  output logic [DIGITS*DW-1:0] count,
  output logic                 tc,
  output logic                 co
);

  localparam int W = DIGITS * DW;
  // One extra bit so MODULUS == 2**DW compares correctly.
  localparam logic [DW:0] LAST = (DW+1)'(MODULUS - 1);
  localparam logic [DW:0] MODV = (DW+1)'(MODULUS);

  logic [W-1:0]      count_p0;
  logic [W-1:0]      count_nxt;
  logic [DIGITS-1:0] term;
  logic [DIGITS-1:0] ripple;
  logic              adv;
  logic              hold;

  function automatic logic [DW-1:0] step_digit(input logic [DW-1:0] d, input logic dir);
    logic [DW:0] ext;
    logic [DW:0] res;
    ext = {1'b0, d};
    if (dir) res = (ext == LAST) ? '0 : ext + (DW+1)'(1);
    else     res = (ext == '0) ? LAST : ext - (DW+1)'(1);
    return DW'(res);
  endfunction

  function automatic logic [DW-1:0] clamp_digit(input logic [DW-1:0] d);
    return ({1'b0, d} >= MODV) ? '0 : d;
  endfunction

  assign adv  = en & cin;
  assign co   = tc & adv;
  assign hold = (SATURATE != 0) && tc;

  // ripple[i]: every lower digit is at its terminal value for this direction
  always_comb begin
    logic acc;
    acc    = 1'b1;
    term   = '0;
    ripple = '0;
    for (int i = 0; i < DIGITS; i++) begin
      ripple[i] = acc;
      if (up) term[i] = ({1'b0, count_p0[i*DW +: DW]} == LAST);
      else    term[i] = (count_p0[i*DW +: DW] == '0);
      acc = acc & term[i];
    end
    tc = acc;
  end

  always_comb begin
    count_nxt = count_p0;
    for (int i = 0; i < DIGITS; i++) begin
      if (clr)
        count_nxt[i*DW +: DW] = '0;
      else if (load)
        count_nxt[i*DW +: DW] = clamp_digit(load_val[i*DW +: DW]);
      else if (adv && !hold && ripple[i])
        count_nxt[i*DW +: DW] = step_digit(count_p0[i*DW +: DW], up);
    end
  end

  // Stage p0: counter state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) count_p0 <= '0;
    else      count_p0 <= count_nxt;
  end

  assign count = count_p0;

endmodule

// File: tb/tb_mod_counter_cascade.sv
// Bench for mod_counter_cascade: BCD, saturating, binary (mod 8) and a
// two-instance cascade, checked against an integer reference model.
module tb_mod_counter_cascade;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, cin = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
  logic [31:0] lv = '0;
  logic [7:0]  ca, cs;
  logic [8:0]  cb;
  logic        tc_a, co_a, tc_s, co_s, tc_b, co_b;

  logic        cen = 1'b0, ccin = 1'b0, cclr = 1'b0, cload = 1'b0;
  logic [15:0] clv = '0;
  logic [7:0]  lo_cnt, hi_cnt;
  logic        lo_tc, lo_co, hi_tc, hi_co;

  int ma = 0, ms = 0, mb = 0, mc = 0;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  mod_counter_cascade #(.DIGITS(2), .DW(4), .MODULUS(10), .SATURATE(0)) dut_a (
    .clk(clk), .rst(rst), .en(en), .cin(cin), .up(up), .clr(clr), .load(load),
    .load_val(lv[7:0]), .count(ca), .tc(tc_a), .co(co_a));

  mod_counter_cascade #(.DIGITS(2), .DW(4), .MODULUS(10), .SATURATE(1)) dut_s (
    .clk(clk), .rst(rst), .en(en), .cin(cin), .up(up), .clr(clr), .load(load),
    .load_val(lv[7:0]), .count(cs), .tc(tc_s), .co(co_s));

  mod_counter_cascade #(.DIGITS(3), .DW(3), .MODULUS(8), .SATURATE(0)) dut_b (
    .clk(clk), .rst(rst), .en(en), .cin(cin), .up(up), .clr(clr), .load(load),
    .load_val(lv[8:0]), .count(cb), .tc(tc_b), .co(co_b));

  mod_counter_cascade #(.DIGITS(2), .DW(4), .MODULUS(10), .SATURATE(0)) dut_lo (
    .clk(clk), .rst(rst), .en(cen), .cin(ccin), .up(1'b1), .clr(cclr), .load(cload),
    .load_val(clv[7:0]), .count(lo_cnt), .tc(lo_tc), .co(lo_co));

  mod_counter_cascade #(.DIGITS(2), .DW(4), .MODULUS(10), .SATURATE(0)) dut_hi (
    .clk(clk), .rst(rst), .en(cen), .cin(lo_co), .up(1'b1), .clr(cclr), .load(cload),
    .load_val(clv[15:8]), .count(hi_cnt), .tc(hi_tc), .co(hi_co));

  // Reference model: the counter is an integer modulo m**d.
  function automatic int pw(int m, int d);
    int r = 1;
    repeat (d) r = r * m;
    return r;
  endfunction

  function automatic logic [31:0] pack(int v, int m, int d, int dw);
    logic [31:0] r = '0;
    for (int i = 0; i < d; i++) begin
      r = r | (32'(v % m) << (i * dw));
      v = v / m;
    end
    return r;
  endfunction

  function automatic int load_int(logic [31:0] l, int m, int d, int dw);
    int r = 0, mul = 1, dig;
    for (int i = 0; i < d; i++) begin
      dig = int'((l >> (i * dw)) & ((32'd1 << dw) - 32'd1));
      if (dig >= m) dig = 0;
      r = r + dig * mul;
      mul = mul * m;
    end
    return r;
  endfunction

  function automatic int nxt(int v, int m, int d, bit sat, bit u, bit a, bit c, bit l, int lval);
    int total = pw(m, d);
    if (c) return 0;
    if (l) return lval;
    if (!a) return v;
    if (u) return (v == total - 1) ? (sat ? v : 0) : v + 1;
    return (v == 0) ? (sat ? v : total - 1) : v - 1;
  endfunction

  function automatic bit tc_of(int v, int m, int d, bit u);
    return u ? (v == pw(m, d) - 1) : (v == 0);
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      ma = 0; ms = 0; mb = 0; mc = 0;
    end else begin
      ma = nxt(ma, 10, 2, 1'b0, up, en & cin, clr, load, load_int(lv, 10, 2, 4));
      ms = nxt(ms, 10, 2, 1'b1, up, en & cin, clr, load, load_int(lv, 10, 2, 4));
      mb = nxt(mb, 8, 3, 1'b0, up, en & cin, clr, load, load_int(lv, 8, 3, 3));
      mc = nxt(mc, 10, 4, 1'b0, 1'b1, cen & ccin, cclr, cload, load_int({16'd0, clv}, 10, 4, 4));
    end
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (ca !== 8'h00) begin errors++; $display("FAIL reset_count got=%h want=00", ca); end
    tick(); tick();
    rst = 1'b1; up = 1'b1; en = 1'b1; cin = 1'b1;
    repeat (37) tick();
    checks++; if (ca !== 8'h37) begin errors++; $display("FAIL count_to_37 got=%h want=37", ca); end
    #1 rst = 1'b0;
    ma = 0; ms = 0; mb = 0; mc = 0;
    #1;
    checks++; if (ca !== 8'h00) begin errors++; $display("FAIL async_reset got=%h want=00", ca); end
    checks++; if (cs !== 8'h00) begin errors++; $display("FAIL async_reset_sat got=%h want=00", cs); end
    tick();
    checks++; if (ca !== 8'h00) begin errors++; $display("FAIL reset_held got=%h want=00", ca); end
    #2 rst = 1'b1; up = 1'b0;
    #1;
    checks++; if (tc_a !== 1'b1) begin errors++; $display("FAIL reset_tc_down got=%b want=1", tc_a); end
    checks++; if (co_a !== 1'b1) begin errors++; $display("FAIL reset_co_down got=%b want=1", co_a); end
    en = 1'b0; #1;
    checks++; if (co_a !== 1'b0) begin errors++; $display("FAIL reset_co_en0 got=%b want=0", co_a); end
  endtask

  task automatic test_up_count();
    en = 1'b1; cin = 1'b1; up = 1'b1; clr = 1'b1;
    tick();
    clr = 1'b0;
    for (int k = 0; k < 100; k++) begin
      logic [7:0] exp;
      exp = 8'(((k / 10) << 4) | (k % 10));
      #1;
      checks++; if (ca !== exp) begin errors++; $display("FAIL up_count k=%0d got=%h want=%h", k, ca, exp); end
      checks++; if (co_a !== (k == 99)) begin errors++; $display("FAIL up_co k=%0d got=%b want=%b", k, co_a, k == 99); end
      tick();
    end
    checks++; if (ca !== 8'h00) begin errors++; $display("FAIL up_wrap got=%h want=00", ca); end
  endtask

  task automatic test_down();
    en = 1'b1; cin = 1'b1; up = 1'b0; load = 1'b1; lv = 32'h20;
    tick();
    load = 1'b0;
    checks++; if (ca !== 8'h20) begin errors++; $display("FAIL down_load got=%h want=20", ca); end
    tick();
    checks++; if (ca !== 8'h19) begin errors++; $display("FAIL down_step1 got=%h want=19", ca); end
    tick();
    checks++; if (ca !== 8'h18) begin errors++; $display("FAIL down_step2 got=%h want=18", ca); end
    clr = 1'b1; tick(); clr = 1'b0; #1;
    checks++; if (co_a !== 1'b1) begin errors++; $display("FAIL down_co_at_00 got=%b want=1", co_a); end
    tick();
    checks++; if (ca !== 8'h99) begin errors++; $display("FAIL down_wrap got=%h want=99", ca); end
    checks++; if (cs !== 8'h00) begin errors++; $display("FAIL sat_down_hold got=%h want=00", cs); end
  endtask

  task automatic test_priority();
    en = 1'b1; cin = 1'b1; up = 1'b1; clr = 1'b1; load = 1'b1; lv = 32'h45;
    tick();
    clr = 1'b0;
    checks++; if (ca !== 8'h00) begin errors++; $display("FAIL clr_over_load got=%h want=00", ca); end
    lv = 32'hC5; tick();
    checks++; if (ca !== 8'h05) begin errors++; $display("FAIL load_clamp got=%h want=05", ca); end
    lv = 32'hFA; tick();
    checks++; if (ca !== 8'h00) begin errors++; $display("FAIL load_clamp_both got=%h want=00", ca); end
    en = 1'b0; lv = 32'h37; tick();
    checks++; if (ca !== 8'h37) begin errors++; $display("FAIL load_en0 got=%h want=37", ca); end
    load = 1'b0; tick();
    checks++; if (ca !== 8'h37) begin errors++; $display("FAIL hold_en0 got=%h want=37", ca); end
  endtask

  task automatic test_saturate();
    en = 1'b1; cin = 1'b1; up = 1'b1; load = 1'b1; lv = 32'h99;
    tick();
    load = 1'b0;
    repeat (3) begin
      #1;
      checks++; if (co_s !== 1'b1) begin errors++; $display("FAIL sat_co got=%b want=1", co_s); end
      tick();
      checks++; if (cs !== 8'h99) begin errors++; $display("FAIL sat_hold got=%h want=99", cs); end
    end
    up = 1'b0; #1;
    checks++; if (co_s !== 1'b0) begin errors++; $display("FAIL sat_co_down got=%b want=0", co_s); end
    tick();
    checks++; if (cs !== 8'h98) begin errors++; $display("FAIL sat_resume got=%h want=98", cs); end
  endtask

  task automatic test_random();
    logic [31:0] exp;
    for (int n = 0; n < 400; n++) begin
      en   = ($urandom_range(0, 3) != 0);
      cin  = ($urandom_range(0, 4) != 0);
      up   = ($urandom_range(0, 7) != 0) ? up : ~up;
      clr  = ($urandom_range(0, 40) == 0);
      load = ($urandom_range(0, 12) == 0);
      lv   = ($urandom_range(0, 1) != 0) ? $urandom : 32'h1FF;
      #1;
      exp = pack(ma, 10, 2, 4);
      checks++; if (ca !== exp[7:0]) begin errors++; $display("FAIL rnd_a n=%0d got=%h want=%h", n, ca, exp[7:0]); end
      exp = pack(ms, 10, 2, 4);
      checks++; if (cs !== exp[7:0]) begin errors++; $display("FAIL rnd_s n=%0d got=%h want=%h", n, cs, exp[7:0]); end
      exp = pack(mb, 8, 3, 3);
      checks++; if (cb !== exp[8:0]) begin errors++; $display("FAIL rnd_b n=%0d got=%h want=%h", n, cb, exp[8:0]); end
      checks++; if (tc_a !== tc_of(ma, 10, 2, up)) begin errors++; $display("FAIL rnd_tc_a n=%0d got=%b", n, tc_a); end
      checks++; if (co_a !== (tc_of(ma, 10, 2, up) & en & cin)) begin errors++; $display("FAIL rnd_co_a n=%0d got=%b", n, co_a); end
      checks++; if (co_s !== (tc_of(ms, 10, 2, up) & en & cin)) begin errors++; $display("FAIL rnd_co_s n=%0d got=%b", n, co_s); end
      checks++; if (co_b !== (tc_of(mb, 8, 3, up) & en & cin)) begin errors++; $display("FAIL rnd_co_b n=%0d got=%b", n, co_b); end
      tick();
    end
    clr = 1'b0; load = 1'b0;
  endtask

  task automatic test_cascade();
    logic [31:0] exp;
    int wraps = 0;
    cen = 1'b1; ccin = 1'b1; cclr = 1'b1;
    tick();
    cclr = 1'b0;
    for (int k = 0; k < 10000; k++) begin
      exp = pack(k, 10, 4, 4);
      checks++; if ({hi_cnt, lo_cnt} !== exp[15:0]) begin errors++; $display("FAIL casc_count k=%0d got=%h want=%h", k, {hi_cnt, lo_cnt}, exp[15:0]); end
      checks++; if (hi_co !== (k == 9999)) begin errors++; $display("FAIL casc_co k=%0d got=%b want=%b", k, hi_co, k == 9999); end
      if (hi_co) wraps++;
      tick();
    end
    checks++; if ({hi_cnt, lo_cnt} !== 16'h0000) begin errors++; $display("FAIL casc_wrap got=%h want=0000", {hi_cnt, lo_cnt}); end
    checks++; if (wraps !== 1) begin errors++; $display("FAIL casc_wrap_count got=%0d want=1", wraps); end
    cload = 1'b1; clv = 16'h9999;
    tick();
    cload = 1'b0; ccin = 1'b0; #1;
    checks++; if (hi_co !== 1'b0 || lo_co !== 1'b0) begin errors++; $display("FAIL casc_cin0_co got=%b%b want=00", hi_co, lo_co); end
    tick(); tick();
    exp = pack(mc, 10, 4, 4);
    checks++; if ({hi_cnt, lo_cnt} !== 16'h9999 || exp[15:0] !== 16'h9999) begin errors++; $display("FAIL casc_cin0_hold got=%h want=9999", {hi_cnt, lo_cnt}); end
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down();
    test_priority();
    test_saturate();
    test_random();
    test_cascade();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
